// File: rtl/slot_pkg.sv
// Shared types, constants and helpers for the slot machine round scorer.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SCORE   = 2'd2
    } slot_state_e;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [9:0] CREDIT_MAX = 10'd999;
    localparam logic [9:0] VALUE_MAX  = 10'd999;

    // One double-dabble iteration over {bcd[11:0], bin[9:0]}: add 3 to any
    // BCD nibble that is 5 or more, then shift the whole register left.
    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        logic [21:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[10+4*i +: 4] >= 4'd5)
                t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
        end
        return {t[20:0], 1'b0};
    endfunction

    // Number of distinct equal pairs among the three reel digits (0, 1 or 3).
    function automatic logic [1:0] equal_pairs(input logic [3:0] d2,
                                               input logic [3:0] d1,
                                               input logic [3:0] d0);
        logic [1:0] n;
        n = 2'd0;
        if (d2 == d1) n = n + 2'd1;
        if (d1 == d0) n = n + 2'd1;
        if (d2 == d0) n = n + 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 10-bit binary to 3-digit BCD converter; one shift per cycle, 10 cycles.
module bin2bcd_seq
    import slot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [21:0] shreg;
    logic [3:0]  cnt;

    // The first shift happens on the loading edge, so the last of the ten
    // lands nine cycles later and done rises together with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (start) begin
            shreg <= dabble_step({12'd0, bin});
            cnt   <= 4'd9;
            done  <= 1'b0;
        end else if (cnt != 4'd0) begin
            shreg <= dabble_step(shreg);
            cnt   <= cnt - 4'd1;
            if (cnt == 4'd1)
                done <= 1'b1;
        end
    end

    assign bcd = shreg[21:10];

endmodule

// File: rtl/slot_scorer.sv
// Round-result consumer: charges the bet at spin start, converts and scores the
// stopped result, and keeps the player's saturating credit balance.
module slot_scorer
    import slot_pkg::*;
#(
    parameter int unsigned BET         = 1,
    parameter int unsigned CREDIT_INIT = 20,
    parameter int unsigned PAIR_MUL    = 2,
    parameter int unsigned JACKPOT_MUL = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  value,
    input  logic        pause,
    input  logic        won,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [9:0]  credits,
    output logic [9:0]  payout,
    output logic        result_valid,
    output logic        busy,
    output logic        game_over,
    output logic        mismatch,
    output slot_state_e state_dbg
);

    localparam logic [9:0] BET_AMT     = 10'(BET);
    localparam logic [9:0] PAIR_PAY    = 10'(PAIR_MUL * BET);
    localparam logic [9:0] JACKPOT_PAY = 10'(JACKPOT_MUL * BET);
    localparam logic [9:0] CREDIT_RST  = 10'(CREDIT_INIT);

    // result_valid is a one-cycle strobe with no ready: the display side must
    // take digits/payout/credits in that cycle; they then hold until the next
    // strobe.

    slot_state_e state;
    logic        pause_meta, pause_s, pause_q;
    logic        won_meta, won_s;
    logic [9:0]  value_lat;
    logic        won_lat;
    logic        round_paid;

    logic        rise, fall, start_conv, charge;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [3:0]  d2, d1, d0;
    logic        in_range, three_eq, one_pair;
    logic [9:0]  score_pay, add_pay;
    logic [10:0] sum11;
    logic [11:0] net12;
    logic [9:0]  credits_next;

    // pause idles high, so its synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_meta <= 1'b1;
            pause_s    <= 1'b1;
            pause_q    <= 1'b1;
            won_meta   <= 1'b0;
            won_s      <= 1'b0;
        end else begin
            pause_meta <= pause;
            pause_s    <= pause_meta;
            pause_q    <= pause_s;
            won_meta   <= won;
            won_s      <= won_meta;
        end
    end

    assign rise       = pause_s & ~pause_q;
    assign fall       = ~pause_s & pause_q;
    assign start_conv = rise && (state == IDLE);
    assign charge     = fall && (credits >= BET_AMT);

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start_conv),
        .bin   (value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign d2       = conv_bcd[11:8];
    assign d1       = conv_bcd[7:4];
    assign d0       = conv_bcd[3:0];
    assign in_range = (value_lat <= VALUE_MAX);
    assign three_eq = in_range && (equal_pairs(d2, d1, d0) == 2'd3);
    assign one_pair = in_range && (equal_pairs(d2, d1, d0) == 2'd1);

    always_comb begin
        score_pay = '0;
        if (round_paid) begin
            if (three_eq)
                score_pay = JACKPOT_PAY;
            else if (one_pair)
                score_pay = PAIR_PAY;
        end
    end

    // Payout and bet can land in the same cycle; apply both, then clamp.
    always_comb begin
        add_pay      = (state == SCORE) ? score_pay : 10'd0;
        sum11        = {1'b0, credits} + {1'b0, add_pay};
        net12        = {1'b0, sum11} - (charge ? {2'b00, BET_AMT} : 12'd0);
        credits_next = credits;
        if (charge && (sum11 < {1'b0, BET_AMT}))
            credits_next = '0;
        else if (net12 > {2'b00, CREDIT_MAX})
            credits_next = CREDIT_MAX;
        else
            credits_next = net12[9:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            digit2       <= BCD_BLANK;
            digit1       <= BCD_BLANK;
            digit0       <= BCD_BLANK;
            payout       <= '0;
            credits      <= CREDIT_RST;
            mismatch     <= 1'b0;
            value_lat    <= '0;
            won_lat      <= 1'b0;
            round_paid   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            credits      <= credits_next;
            if (fall)
                round_paid <= charge;
            case (state)
                IDLE: begin
                    if (rise) begin
                        value_lat <= value;
                        won_lat   <= won_s;
                        state     <= CONVERT;
                        busy      <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (conv_done)
                        state <= SCORE;
                end
                SCORE: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                    payout       <= score_pay;
                    digit2       <= in_range ? d2 : BCD_BLANK;
                    digit1       <= in_range ? d1 : BCD_BLANK;
                    digit0       <= in_range ? d0 : BCD_BLANK;
                    if (three_eq != won_lat)
                        mismatch <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign game_over = (credits < BET_AMT);
    assign state_dbg = state;

endmodule

// File: doc/slot_scorer.md
# slot_scorer

Round-result consumer for the slot machine. Watches the game's `pause`/`won`/`out` outputs and charges the bet when a spin starts. When the spin stops, it latches the 10-bit result and converts it to three BCD reel digits. It then scores the round and keeps the player's credit balance. It sits between the game mode block and the seven-segment/LED display logic, on the 50 MHz system clock.

## Interface
Parameters:
- `BET`, 1: credits charged per spin.
- `CREDIT_INIT`, 20: balance after reset.
- `PAIR_MUL`, 2: payout multiplier for exactly two equal digits.
- `JACKPOT_MUL`, 10: payout multiplier for three equal digits.

Ports:
- `clk` in 1: 50 MHz system clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `value` in 10: spin result from the game block, in the div_clk domain.
- `pause` in 1: 1 = stopped/idle, 0 = spinning. In the div_clk domain.
- `won` in 1: game block's three-of-a-kind flag. In the div_clk domain.
- `digit2`, `digit1`, `digit0` out 4 each: BCD reel digits, hundreds/tens/units.
- `credits` out 10: balance, 0..999.
- `payout` out 10: credits awarded in the last scored round.
- `result_valid` out 1: one-cycle pulse when the digits, payout and credits update.
- `busy` out 1: high during CONVERT/SCORE.
- `game_over` out 1: high while `credits < BET`.
- `mismatch` out 1: sticky. Set when the locally computed jackpot disagrees with `won`.

## Operation
- Reset values:
  - Digits are `BCD_BLANK` (4'hF).
  - `credits = CREDIT_INIT`.
  - `payout = 0`.
  - `result_valid`, `busy` and `mismatch` are 0.
  - `game_over = (CREDIT_INIT < BET)`.
  - FSM in IDLE.
  - Synchronizers are loaded with 1 for `pause` and 0 for `won`/`value` capture.
- Inputs: `pause` and `won` pass through 2-flop synchronizers. `value` is sampled only when the synchronized `pause` rises; it is stable then because the generator is frozen.
- Spin start (synchronized `pause` falls):
  - If `credits >= BET`: `credits -= BET` and `round_paid = 1`.
  - Otherwise `round_paid = 0`; the result is converted and displayed, but `payout` is forced to 0.
- Spin stop (synchronized `pause` rises, FSM in IDLE): latch `value` and `won`, then go to CONVERT.
- A rising edge while not in IDLE is ignored; that round stays unscored.
- FSM states:
  - IDLE: waits for a stop edge.
  - CONVERT: exactly 10 cycles of shift-add-3 through `bin2bcd_seq`.
  - SCORE: one cycle.
  - Then back to IDLE.
- Scoring:
  - Out-of-range: if latched value > 999, all digits are `BCD_BLANK` and payout = 0.
  - Jackpot: d2==d1==d0 pays `JACKPOT_MUL*BET`.
  - Pair: exactly one equal pair among (d2,d1), (d1,d0), (d2,d0) pays `PAIR_MUL*BET`.
  - Otherwise payout = 0.
- Credits: `credits += payout`, saturating at 999. The sum is computed in 11 bits, then clamped.
- `mismatch` is set in SCORE when (three-equal AND in-range) != latched `won`. Only `rst` clears it.
- `game_over` is combinational from `credits`.
- A spin start and a SCORE update in the same cycle are applied as the net value: `credits + payout - BET`, clamped to 0..999.
- Reset mid-CONVERT abandons the conversion and restores all reset values.

## Timing
- Let T be the cycle the synchronized `pause` is first seen high. Raw input to synchronized is 2 cycles.
- T+1 to T+10: CONVERT, with `busy` = 1.
- T+11: SCORE.
- T+12: digits, `payout` and `credits` are updated and `result_valid` = 1 for exactly one cycle; `busy` = 0.
- Total latency is 12 cycles, far shorter than one div_clk period (5,000,000 cycles), so back-to-back rounds never overlap in normal use.
- The bet deduction is visible on `credits` one cycle after the synchronized falling edge.

## Structure
- Package `slot_pkg` holds:
  - The state enum (IDLE, CONVERT, SCORE).
  - `BCD_BLANK = 4'hF`.
  - `CREDIT_MAX = 999`.
  - `VALUE_MAX = 999`.
- Sub-module `bin2bcd_seq`:
  - 10-bit iterative double-dabble.
  - Ports: `start`, `bin[9:0]`, `done`, `bcd[11:0]`; conversion takes 10 cycles.
- Synchronizers, edge detection, the FSM and the credit arithmetic live in the top module.

## Test plan
- Reset with defaults: `credits` = 20, digits = F/F/F, `game_over` = 0; spin with value 777 and `won` = 1 → falling edge gives credits 19; 12 cycles after the synchronized rise, digits 7/7/7, payout 10, credits 29, one `result_valid` pulse.
- Value 383, `won` = 0 → digits 3/8/3, payout 2, credits net +1. Value 123 → payout 0, credits net −1.
- Value 1010 → digits F/F/F, payout 0, `mismatch` stays 0.
- Set `CREDIT_INIT = 0`: spin → credits stays 0, `game_over` = 1, value 555 scores payout 0. Separately, with credits 995, a jackpot clamps credits to 999.
- Value 444 with `won` = 0 → `mismatch` goes to 1 and stays set across later rounds until `rst`.
- Assert `rst` low at T+5 → all outputs return to reset values immediately; no `result_valid` pulse follows.
